// File: rtl/rdm_pkg.sv
// rdm_pkg: the types and sizes shared by the input-buffer write path.
// It defines the write FSM state encoding, the LLR width, the lanes per
// input-buffer word, the word width, the address width and the width of
// the LLR count.
package rdm_pkg;

    localparam int LLR_W        = 6;
    localparam int LLR_PER_WORD = 16;
    localparam int WORD_W       = LLR_W * LLR_PER_WORD;  // 96
    localparam int ADDR_W       = 16;
    localparam int CNT_W        = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fsm_ib_wr_if.sv
// fsm_ib_wr_if: the link between the write FSM and the LLR packer.
//   master (FSM side)   : drives clr, push and din; reads word, lane and full
//   slave  (packer side): reads clr, push and din; drives word, lane and full
// word is the packed lanes with the current push already merged in, so the
// FSM can register a completed word in the same cycle its last LLR arrives.
interface fsm_ib_wr_if
    import rdm_pkg::*;
#(
    parameter int LLR_W = rdm_pkg::LLR_W,
    parameter int LANES = rdm_pkg::LLR_PER_WORD
);
    localparam int LANE_W = $clog2(LANES);

    logic                     clr;   // discard the partial word, lane back to 0
    logic                     push;  // insert din at the current lane
    logic [LLR_W-1:0]         din;
    logic [LLR_W*LANES-1:0]   word;  // lanes, with this cycle's insert merged in
    logic [LANE_W-1:0]        lane;  // next lane to be filled
    logic                     full;  // this push completes the word

    modport master (output clr, push, din, input word, lane, full);
    modport slave  (input clr, push, din, output word, lane, full);
endinterface

// File: rtl/llr_packer.sv
// llr_packer: packs incoming LLRs into one input-buffer word, lane by lane.
// Ports:
//   clk  - clock
//   srst - synchronous reset, active high
//   pk   - packer link (slave side): clr, push and din in; word, lane and full out
// The register clears itself when the last lane is pushed. Lanes that were
// never written therefore read as zero, which gives a zero-padded partial word.
module llr_packer
    import rdm_pkg::*;
#(
    parameter int LLR_W = rdm_pkg::LLR_W,
    parameter int LANES = rdm_pkg::LLR_PER_WORD
) (
    input  logic         clk,
    input  logic         srst,
    fsm_ib_wr_if.slave   pk
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane_reg;
    logic              full;

    assign full    = pk.push && (lane_reg == LANE_W'(LANES - 1));
    assign pk.full = full;
    assign pk.lane = lane_reg;

    always_ff @(posedge clk) begin
        if (srst || pk.clr || full) begin
            lane_reg <= '0;
        end else if (pk.push) begin
            lane_reg <= lane_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic             sel;
            logic [LLR_W-1:0] llr_reg;

            assign sel = pk.push && (lane_reg == LANE_W'(gi));

            // Merge the current push so that a completed word is visible at once.
            assign pk.word[gi*LLR_W +: LLR_W] = sel ? pk.din : llr_reg;

            always_ff @(posedge clk) begin
                if (srst || pk.clr || full) begin
                    llr_reg <= '0;
                end else if (sel) begin
                    llr_reg <= pk.din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fsm_ib_wr.sv
// fsm_ib_wr: writes one codeword of E LLRs into the input buffer. Each
// buffer word holds 16 LLRs.
// Ports:
//   i_core_clk                    - clock
//   i_rx_rstn / i_rx_fsm_rstn     - synchronous resets, active low
//   i_Current_Combine_E01_Size    - E, the number of LLRs, latched when a start is accepted
//   i_Write_Start                 - start pulse, acted on only in IDLE
//   i_LLR_Valid/i_LLR_Data/o_LLR_Ready - LLR stream handshake
//   o_Input_Buffer_*              - registered word write: address, data and enable
//   o_Write_Done                  - one-cycle pulse when the codeword is complete
//   o_RDM_Data_Available          - high from done until the next accepted start
// Operation: a full word is written in the cycle after its 16th LLR is
// accepted. A trailing partial word, zero-padded, is written in FLUSH.
module fsm_ib_wr
    import rdm_pkg::*;
#(
    parameter int LLR_W        = rdm_pkg::LLR_W,
    parameter int LLR_PER_WORD = rdm_pkg::LLR_PER_WORD
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rstn,
    input  logic                          i_rx_fsm_rstn,
    input  logic [CNT_W-1:0]              i_Current_Combine_E01_Size,
    input  logic                          i_Write_Start,
    input  logic                          i_LLR_Valid,
    input  logic [LLR_W-1:0]              i_LLR_Data,
    output logic                          o_LLR_Ready,
    output logic [ADDR_W-1:0]             o_Input_Buffer_Offset_Address,
    output logic [LLR_W*LLR_PER_WORD-1:0] o_Input_Buffer_Wr_Data,
    output logic                          o_Input_Buffer_Wr_Enable,
    output logic                          o_Write_Done,
    output logic                          o_RDM_Data_Available
);
    state_t                        state_reg;
    logic [CNT_W-1:0]              e_reg;
    logic [CNT_W-1:0]              cnt_reg;
    logic [ADDR_W-1:0]             waddr_reg;  // address of the next word to be written
    logic [ADDR_W-1:0]             addr_reg;
    logic [LLR_W*LLR_PER_WORD-1:0] data_reg;
    logic                          wen_reg;
    logic                          done_reg;
    logic                          avail_reg;
    logic                          rst_active;
    logic                          accept;

    fsm_ib_wr_if #(.LLR_W(LLR_W), .LANES(LLR_PER_WORD)) pk_if ();

    // Either reset clears everything, including any partial word in the packer.
    assign rst_active = !i_rx_rstn || !i_rx_fsm_rstn;

    assign o_LLR_Ready = (state_reg == ST_FILL) && (cnt_reg < e_reg);
    assign accept      = o_LLR_Ready && i_LLR_Valid;

    assign pk_if.push = accept;
    assign pk_if.din  = i_LLR_Data;
    assign pk_if.clr  = ((state_reg == ST_IDLE) && i_Write_Start) || (state_reg == ST_FLUSH);

    llr_packer #(.LLR_W(LLR_W), .LANES(LLR_PER_WORD)) u_packer (
        .clk  (i_core_clk),
        .srst (rst_active),
        .pk   (pk_if.slave)
    );

    always_ff @(posedge i_core_clk) begin
        if (rst_active) begin
            state_reg <= ST_IDLE;
            e_reg     <= '0;
            cnt_reg   <= '0;
            waddr_reg <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            wen_reg   <= 1'b0;
            done_reg  <= 1'b0;
            avail_reg <= 1'b0;
        end else begin
            wen_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_Write_Start) begin
                        e_reg     <= i_Current_Combine_E01_Size;
                        cnt_reg   <= '0;
                        waddr_reg <= '0;
                        addr_reg  <= '0;
                        avail_reg <= 1'b0;
                        state_reg <= (i_Current_Combine_E01_Size != '0) ? ST_FILL : ST_DONE;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (pk_if.full) begin
                            wen_reg   <= 1'b1;
                            data_reg  <= pk_if.word;
                            addr_reg  <= waddr_reg;
                            waddr_reg <= waddr_reg + 1'b1;
                        end
                        if ((cnt_reg + 1'b1) == e_reg) begin
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // A nonzero lane index means a partial word is still pending.
                    if (pk_if.lane != '0) begin
                        wen_reg   <= 1'b1;
                        data_reg  <= pk_if.word;
                        addr_reg  <= waddr_reg;
                        waddr_reg <= waddr_reg + 1'b1;
                    end
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    avail_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_Input_Buffer_Offset_Address = addr_reg;
    assign o_Input_Buffer_Wr_Data        = data_reg;
    assign o_Input_Buffer_Wr_Enable      = wen_reg;
    assign o_Write_Done                  = done_reg;
    assign o_RDM_Data_Available          = avail_reg;

endmodule

// File: tb/tb_fsm_ib_wr.sv
module tb_fsm_ib_wr;
    logic        clk = 1'b0;
    logic        rx_rstn;
    logic        fsm_rstn;
    logic [13:0] e_size;
    logic        wr_start;
    logic        llr_valid;
    logic [5:0]  llr_data;
    logic        llr_ready;
    logic [15:0] wr_addr;
    logic [95:0] wr_data;
    logic        wr_en;
    logic        wr_done;
    logic        rdm_avail;

    always #5 clk = ~clk;

    fsm_ib_wr dut (
        .i_core_clk                    (clk),
        .i_rx_rstn                     (rx_rstn),
        .i_rx_fsm_rstn                 (fsm_rstn),
        .i_Current_Combine_E01_Size    (e_size),
        .i_Write_Start                 (wr_start),
        .i_LLR_Valid                   (llr_valid),
        .i_LLR_Data                    (llr_data),
        .o_LLR_Ready                   (llr_ready),
        .o_Input_Buffer_Offset_Address (wr_addr),
        .o_Input_Buffer_Wr_Data        (wr_data),
        .o_Input_Buffer_Wr_Enable      (wr_en),
        .o_Write_Done                  (wr_done),
        .o_RDM_Data_Available          (rdm_avail)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model. It collects the accepted LLRs into a plain array and
    // builds each expected word from that array by arithmetic.
    int          ph;      // 0 idle, 1 filling, 2 flushing, 3 done
    int          m_e, m_cnt, m_words;
    logic [5:0]  m_llr [0:16383];
    logic        e_wen, e_done, e_avail;
    logic [15:0] e_addr;
    logic [95:0] e_data;

    function automatic logic [95:0] pack_word(input int w);
        logic [95:0] d = '0;
        for (int i = 0; i < 16; i++)
            if (16*w + i < m_cnt) d[6*i +: 6] = m_llr[16*w + i];
        return d;
    endfunction

    task automatic emit_word();
        e_wen  = 1'b1;
        e_addr = 16'(m_words);
        e_data = pack_word(m_words);
        m_words++;
    endtask

    always @(posedge clk) begin
        if (!rx_rstn || !fsm_rstn) begin
            ph = 0; m_e = 0; m_cnt = 0; m_words = 0;
            e_wen = 0; e_done = 0; e_avail = 0; e_addr = 0; e_data = 0;
        end else begin
            e_wen  = 1'b0;
            e_done = 1'b0;
            case (ph)
                0: if (wr_start) begin
                    m_e = int'(e_size); m_cnt = 0; m_words = 0; e_avail = 1'b0;
                    ph = (m_e > 0) ? 1 : 3;
                end
                1: if (llr_valid) begin
                    m_llr[m_cnt] = llr_data;
                    m_cnt++;
                    if (m_cnt % 16 == 0) emit_word();
                    if (m_cnt == m_e) ph = 2;
                end
                2: begin
                    if (m_cnt % 16 != 0) emit_word();
                    ph = 3;
                end
                default: begin
                    e_done = 1'b1; e_avail = 1'b1; ph = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_enable", 96'(wr_en), 96'(e_wen));
            check("write_done", 96'(wr_done), 96'(e_done));
            check("data_available", 96'(rdm_avail), 96'(e_avail));
            check("llr_ready", 96'(llr_ready), 96'(ph == 1 && m_cnt < m_e));
            if (wr_en || e_wen) begin
                check("wr_addr", 96'(wr_addr), 96'(e_addr));
                check("wr_data", wr_data, e_data);
            end
        end
    end

    // Transaction monitor: one line for each write and each done pulse.
    int          wr_total = 0, done_total = 0, done_cyc = 0;
    logic [15:0] last_addr;
    logic [95:0] last_data;
    always @(negedge clk) begin
        if (wr_en) begin
            wr_total++;
            last_addr = wr_addr;
            last_data = wr_data;
            $display("write addr=%0d data=%h", wr_addr, wr_data);
        end
        if (wr_done) begin
            done_total++;
            done_cyc = cyc;
            $display("write_done at cycle %0d", cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int e, output int s);
        wr_start = 1'b1;
        e_size   = 14'(e);
        s        = cyc;
        tick();
        wr_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap, input int mul, input int add, input int restart_at);
        int idx = 0;
        int k   = 0;
        bit sent = 1'b0;
        while (idx < n && k < 2000) begin
            llr_valid = gap ? (k % 2 == 0) : 1'b1;
            llr_data  = 6'((idx * mul + add) % 64);
            if (restart_at >= 0 && idx == restart_at && !sent) begin
                wr_start = 1'b1; e_size = 14'd5; sent = 1'b1;
            end else begin
                wr_start = 1'b0;
            end
            @(negedge clk);
            if (llr_valid && llr_ready) idx++;
            tick();
            k++;
        end
        llr_valid = 1'b0;
        wr_start  = 1'b0;
        if (idx < n) check("feed_timeout", 96'(idx), 96'(n));
    endtask

    task automatic wait_done(input int base);
        int w = 0;
        while (done_total == base && w < 100) begin
            tick();
            w++;
        end
        check("done_count", 96'(done_total - base), 96'd1);
    endtask

    int s, wb, db;

    initial begin
        rx_rstn = 1'b0; fsm_rstn = 1'b1; e_size = '0; wr_start = 1'b0;
        llr_valid = 1'b0; llr_data = '0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        check("rst_wen", 96'(wr_en), 96'd0);
        check("rst_addr", 96'(wr_addr), 96'd0);
        check("rst_data", wr_data, 96'd0);
        check("rst_done", 96'(wr_done), 96'd0);
        check("rst_avail", 96'(rdm_avail), 96'd0);
        check("rst_ready", 96'(llr_ready), 96'd0);
        rx_rstn = 1'b1;
        tick();

        // E=129, continuous valid: 9 writes, the last holding only LLR128.
        wb = wr_total; db = done_total;
        do_start(129, s);
        feed(129, 1'b0, 5, 1, -1);
        wait_done(db);
        check("e129_writes", 96'(wr_total - wb), 96'd9);
        check("e129_last_addr", 96'(last_addr), 96'd8);
        check("e129_last_word", last_data, 96'd1);
        tick();

        // E=16, LLR k = k: a single full word and no flush write.
        wb = wr_total; db = done_total;
        do_start(16, s);
        feed(16, 1'b0, 1, 0, -1);
        wait_done(db);
        check("e16_writes", 96'(wr_total - wb), 96'd1);
        check("e16_addr", 96'(last_addr), 96'd0);
        check("e16_word", last_data, {6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd9, 6'd8,
                                      6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0});
        tick();

        // E=0: no writes, done two cycles after the start.
        wb = wr_total; db = done_total;
        do_start(0, s);
        wait_done(db);
        check("e0_writes", 96'(wr_total - wb), 96'd0);
        check("e0_latency", 96'(done_cyc - s), 96'd2);
        check("e0_avail", 96'(rdm_avail), 96'd1);
        tick();

        // E=40, valid on alternate cycles: 3 writes, the last half filled.
        wb = wr_total; db = done_total;
        do_start(40, s);
        check("start_clears_avail", 96'(rdm_avail), 96'd0);
        feed(40, 1'b1, 3, 7, -1);
        wait_done(db);
        check("e40_writes", 96'(wr_total - wb), 96'd3);
        check("e40_last_addr", 96'(last_addr), 96'd2);
        check("e40_last_word", last_data, {48'd0, 6'd60, 6'd57, 6'd54, 6'd51,
                                           6'd48, 6'd45, 6'd42, 6'd39});
        tick();

        // FSM reset after 50 of 129 LLRs, then a clean restart with E=16.
        wb = wr_total;
        do_start(129, s);
        feed(50, 1'b0, 1, 0, -1);
        check("pre_rst_writes", 96'(wr_total - wb), 96'd3);
        fsm_rstn = 1'b0;
        tick(); tick();
        check("mid_rst_wen", 96'(wr_en), 96'd0);
        check("mid_rst_addr", 96'(wr_addr), 96'd0);
        check("mid_rst_data", wr_data, 96'd0);
        check("mid_rst_avail", 96'(rdm_avail), 96'd0);
        check("mid_rst_ready", 96'(llr_ready), 96'd0);
        fsm_rstn = 1'b1;
        wb = wr_total; db = done_total;
        for (int i = 0; i < 20; i++) tick();
        check("post_rst_writes", 96'(wr_total - wb), 96'd0);
        check("post_rst_done", 96'(done_total - db), 96'd0);
        do_start(16, s);
        feed(16, 1'b0, 1, 0, -1);
        wait_done(db);
        check("restart_writes", 96'(wr_total - wb), 96'd1);
        check("restart_addr", 96'(last_addr), 96'd0);
        tick();

        // A second start during FILL (asking for E=5) must be ignored.
        wb = wr_total; db = done_total;
        do_start(40, s);
        feed(40, 1'b0, 2, 5, 10);
        wait_done(db);
        for (int i = 0; i < 5; i++) tick();
        check("restart_ignored_writes", 96'(wr_total - wb), 96'd3);
        check("restart_ignored_addr", 96'(last_addr), 96'd2);
        check("restart_ignored_done", 96'(done_total - db), 96'd1);
        check("restart_ignored_word", last_data, {48'd0, 6'd19, 6'd17, 6'd15, 6'd13,
                                                  6'd11, 6'd9, 6'd7, 6'd5});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
